// File: rtl/hermes_pkg.sv
// Shared Hermes switch-control types: port indices, header field layout, FSM encoding and XY routing.
// Pure declarations, so there is no latency and no backpressure.
package hermes_pkg;

  localparam int NPORT = 5;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_t;

  localparam int HDR_X_MSB = 15;
  localparam int HDR_X_LSB = 8;
  localparam int HDR_Y_MSB = 7;
  localparam int HDR_Y_LSB = 0;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ARB   = 5'b00010,
    S_ROUTE = 5'b00100,
    S_GRANT = 5'b01000,
    S_WAIT  = 5'b10000
  } sw_fsm_t;

  // X is resolved before Y; the comparison is unsigned.
  function automatic port_t xy_route(input logic [7:0] dst_x, input logic [7:0] dst_y,
                                     input logic [7:0] cur_x, input logic [7:0] cur_y);
    port_t t;
    if (dst_x > cur_x)      t = EAST;
    else if (dst_x < cur_x) t = WEST;
    else if (dst_y > cur_y) t = NORTH;
    else if (dst_y < cur_y) t = SOUTH;
    else                    t = LOCAL;
    return t;
  endfunction

endpackage

// File: rtl/hermes_switch_control_if.sv
// Links the five input buffers to the switch controller: requests and header flits go in, grants and crossbar selects come out.
// A buffer holds req until it sees req_ack; out_busy and in_valid show the live allocations.
interface hermes_switch_control_if #(parameter int FLIT_SIZE = 32);
  import hermes_pkg::*;

  logic [NPORT-1:0]                req;
  logic [NPORT-1:0]                sending;
  logic [NPORT-1:0][FLIT_SIZE-1:0] header;
  logic [NPORT-1:0]                req_ack;
  logic [NPORT-1:0]                out_busy;
  logic [NPORT-1:0][2:0]           out_sel;
  logic [NPORT-1:0][2:0]           in_sel;
  logic [NPORT-1:0]                in_valid;

  modport master (
    output req, sending, header,
    input  req_ack, out_busy, out_sel, in_sel, in_valid
  );

  modport slave (
    input  req, sending, header,
    output req_ack, out_busy, out_sel, in_sel, in_valid
  );

endinterface

// File: rtl/hermes_rr_arbiter.sv
// Round-robin choice of the first requesting input port after ptr.
// Purely combinational with zero latency; requests are only sampled, so there is no backpressure.
module hermes_rr_arbiter
  import hermes_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       grant,
  output logic             valid
);

  logic [2:0] idx;

  // Scanning from the farthest candidate to the nearest lets the nearest one win.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NPORT; i >= 1; i--) begin
      idx = 3'((int'(ptr) + i) % NPORT);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes router switch control: XY route, round-robin output allocation, and release when sending falls.
// req to req_ack takes 3 cycles; when the target is busy the ack is withheld and the request is retried on a later pass.
module hermes_switch_control
  import hermes_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int X_ADDR    = 0,
  parameter int Y_ADDR    = 0
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  hermes_switch_control_if.slave sw
);

  sw_fsm_t               state;
  logic [2:0]            ptr;
  logic [2:0]            sel;
  logic [NPORT-1:0]      req_ack;
  logic [NPORT-1:0]      out_busy;
  logic [NPORT-1:0]      in_valid;
  logic [NPORT-1:0]      sending_q;
  logic [NPORT-1:0][2:0] out_sel;
  logic [NPORT-1:0][2:0] in_sel;

  logic [2:0]            arb_gnt;
  logic                  arb_vld;
  logic [7:0]            dst_x;
  logic [7:0]            dst_y;
  port_t                 target;
  logic                  grant_ok;
  logic [NPORT-1:0]      rel;
  logic [NPORT-1:0]      clr_busy;
  logic [NPORT-1:0]      busy_nxt;
  logic [NPORT-1:0]      valid_nxt;

  hermes_rr_arbiter u_arb (
    .req   (sw.req),
    .ptr   (ptr),
    .grant (arb_gnt),
    .valid (arb_vld)
  );

  assign dst_x  = sw.header[sel][HDR_X_MSB:HDR_X_LSB];
  assign dst_y  = sw.header[sel][HDR_Y_MSB:HDR_Y_LSB];
  assign target = xy_route(dst_x, dst_y, 8'(X_ADDR), 8'(Y_ADDR));

  // The grant is committed on the edge that leaves S_ROUTE, so the registered ack and
  // allocation are visible during S_GRANT. The check uses the busy state before that edge.
  assign grant_ok = (state == S_ROUTE) && sw.req[sel] && !out_busy[target];
  assign rel      = sending_q & ~sw.sending & in_valid;

  always_comb begin
    clr_busy = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (rel[p]) clr_busy[in_sel[p]] = 1'b1;
    end
    busy_nxt  = out_busy & ~clr_busy;
    valid_nxt = in_valid & ~rel;
    if (grant_ok) begin
      busy_nxt[target] = 1'b1;
      valid_nxt[sel]   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      ptr       <= LOCAL;
      sel       <= '0;
      req_ack   <= '0;
      out_busy  <= '0;
      in_valid  <= '0;
      sending_q <= '0;
      out_sel   <= '0;
      in_sel    <= '0;
    end else begin
      sending_q <= sw.sending;
      out_busy  <= busy_nxt;
      in_valid  <= valid_nxt;
      req_ack   <= '0;
      case (state)
        S_IDLE: begin
          if (|sw.req) state <= S_ARB;
        end
        S_ARB: begin
          if (arb_vld) begin
            sel   <= arb_gnt;
            ptr   <= arb_gnt;
            state <= S_ROUTE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          if (grant_ok) begin
            req_ack[sel]    <= 1'b1;
            out_sel[target] <= sel;
            in_sel[sel]     <= target;
          end
          state <= S_GRANT;
        end
        S_GRANT: state <= S_WAIT;
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sw.req_ack  = req_ack;
  assign sw.out_busy = out_busy;
  assign sw.out_sel  = out_sel;
  assign sw.in_sel   = in_sel;
  assign sw.in_valid = in_valid;

endmodule

// File: tb/tb_hermes_switch_control.sv
// Directed bench for hermes_switch_control at router (1,1): a routing table plus hand-timed multi-cycle sequences.
`timescale 1ns/1ps
module tb_hermes_switch_control;
  import hermes_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [NPORT-1:0] ack_prev = '0;

  hermes_switch_control_if #(.FLIT_SIZE(32)) sw_if ();

  hermes_switch_control #(.FLIT_SIZE(32), .X_ADDR(1), .Y_ADDR(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sw     (sw_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hdr;
    logic [2:0]  tgt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int port, input int max_cyc, output int cyc);
    cyc = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk_i);
      if (sw_if.req_ack[port]) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    sw_if.req      = '0;
    sw_if.sending  = '0;
    sw_if.header   = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // A grant must be one-hot and must never last two cycles.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && sw_if.req_ack != '0) begin
      n_cmp++;
      if ($countones(sw_if.req_ack) != 1 || ack_prev != '0) begin
        n_err++;
        $display("FAIL ack_onehot_single: ack=%b prev=%b", sw_if.req_ack, ack_prev);
      end
    end
    ack_prev = sw_if.req_ack;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[8];
    int          cyc;
    int          order[$];
    int          when[$];
    logic [4:0]  ack_acc;

    vecs[0] = '{32'h0000_0201, 3'd0};  // dx=2 -> EAST
    vecs[1] = '{32'h0000_0001, 3'd1};  // dx=0 -> WEST
    vecs[2] = '{32'h0000_0102, 3'd2};  // dy=2 -> NORTH
    vecs[3] = '{32'h0000_0100, 3'd3};  // dy=0 -> SOUTH
    vecs[4] = '{32'h0000_0101, 3'd4};  // here -> LOCAL
    vecs[5] = '{32'hABCD_0201, 3'd0};  // upper header bits ignored
    vecs[6] = '{32'h0000_FF01, 3'd0};  // dx=255 is unsigned-greater -> EAST
    vecs[7] = '{32'h0000_0180, 3'd2};  // dy=128 is unsigned-greater -> NORTH

    rst_ni = 1'b0;
    do_reset();
    check("reset req_ack",  32'(sw_if.req_ack),  32'h0);
    check("reset out_busy", 32'(sw_if.out_busy), 32'h0);
    check("reset in_valid", 32'(sw_if.in_valid), 32'h0);
    check("reset out_sel",  32'(sw_if.out_sel),  32'h0);
    check("reset in_sel",   32'(sw_if.in_sel),   32'h0);

    // Routing table: LOCAL requests each header, then releases the allocation.
    for (int v = 0; v < 8; v++) begin
      sw_if.header[LOCAL] = vecs[v].hdr;
      sw_if.req[LOCAL]    = 1'b1;
      wait_ack(4, 10, cyc);
      sw_if.req[LOCAL] = 1'b0;
      check($sformatf("v%0d ack_latency", v), 32'(cyc), 32'd3);
      check($sformatf("v%0d in_sel_local", v), 32'(sw_if.in_sel[LOCAL]), 32'(vecs[v].tgt));
      check($sformatf("v%0d out_sel_tgt", v), 32'(sw_if.out_sel[vecs[v].tgt]), 32'd4);
      check($sformatf("v%0d out_busy", v), 32'(sw_if.out_busy), 32'(5'b00001 << vecs[v].tgt));
      check($sformatf("v%0d in_valid", v), 32'(sw_if.in_valid), 32'h10);
      sw_if.sending[LOCAL] = 1'b1;
      @(negedge clk_i);
      sw_if.sending[LOCAL] = 1'b0;
      @(negedge clk_i);
      check($sformatf("v%0d release busy", v), 32'(sw_if.out_busy), 32'h0);
      check($sformatf("v%0d release valid", v), 32'(sw_if.in_valid), 32'h0);
    end

    // EAST, NORTH and LOCAL all request together, each to a distinct output.
    do_reset();
    sw_if.header[EAST]  = 32'h0001;
    sw_if.header[NORTH] = 32'h0100;
    sw_if.header[LOCAL] = 32'h0201;
    sw_if.req = 5'b10101;
    for (int n = 1; n <= 40 && order.size() < 3; n++) begin
      @(negedge clk_i);
      for (int p = 0; p < NPORT; p++) begin
        if (sw_if.req_ack[p]) begin
          order.push_back(p);
          when.push_back(n);
          sw_if.req[p] = 1'b0;
        end
      end
    end
    check("multi ack_count", 32'(order.size()), 32'd3);
    while (order.size() < 3) begin
      order.push_back(-1);
      when.push_back(0);
    end
    check("multi first_port",  32'(order[0]), 32'd0);
    check("multi second_port", 32'(order[1]), 32'd2);
    check("multi third_port",  32'(order[2]), 32'd4);
    check("multi first_latency", 32'(when[0]), 32'd3);
    check("multi gap1_ge4", 32'((when[1] - when[0]) >= 4), 32'd1);
    check("multi gap2_ge4", 32'((when[2] - when[1]) >= 4), 32'd1);
    check("multi out_busy", 32'(sw_if.out_busy), 32'h0B);
    check("multi in_valid", 32'(sw_if.in_valid), 32'h15);
    check("multi out_sel_west",  32'(sw_if.out_sel[WEST]),  32'd0);
    check("multi out_sel_south", 32'(sw_if.out_sel[SOUTH]), 32'd2);
    check("multi out_sel_east",  32'(sw_if.out_sel[EAST]),  32'd4);

    // WEST holds EAST; LOCAL wants EAST and is only served after WEST releases.
    do_reset();
    sw_if.header[WEST] = 32'h0201;
    sw_if.req[WEST]    = 1'b1;
    wait_ack(1, 10, cyc);
    check("block west_ack", 32'(cyc), 32'd3);
    sw_if.req[WEST]     = 1'b0;
    sw_if.sending[WEST] = 1'b1;
    sw_if.header[LOCAL] = 32'h0201;
    sw_if.req[LOCAL]    = 1'b1;
    wait_ack(4, 15, cyc);
    check("block no_ack_while_busy", 32'(cyc), 32'hFFFF_FFFF);
    check("block east_busy", 32'(sw_if.out_busy[EAST]), 32'd1);
    sw_if.sending[WEST] = 1'b0;
    @(negedge clk_i);
    check("block east_freed", 32'(sw_if.out_busy[EAST]), 32'd0);
    check("block west_invalid", 32'(sw_if.in_valid[WEST]), 32'd0);
    wait_ack(4, 15, cyc);
    sw_if.req[LOCAL] = 1'b0;
    check("block local_acked", 32'(cyc > 0), 32'd1);
    check("block in_sel_local", 32'(sw_if.in_sel[LOCAL]), 32'd0);
    check("block out_sel_east", 32'(sw_if.out_sel[EAST]), 32'd4);
    check("block out_busy", 32'(sw_if.out_busy), 32'h01);
    check("block in_valid", 32'(sw_if.in_valid), 32'h10);

    // Release lands on the same edge as LOCAL's grant decision: no ack that pass, ack on the retry.
    do_reset();
    sw_if.header[WEST] = 32'h0201;
    sw_if.req[WEST]    = 1'b1;
    wait_ack(1, 10, cyc);
    check("race west_ack", 32'(cyc), 32'd3);
    sw_if.req[WEST]     = 1'b0;
    sw_if.sending[WEST] = 1'b1;
    sw_if.header[LOCAL] = 32'h0201;
    sw_if.req[LOCAL]    = 1'b1;
    repeat (4) @(negedge clk_i);   // WAIT, IDLE, ARB, ROUTE
    sw_if.sending[WEST] = 1'b0;
    @(negedge clk_i);
    check("race no_ack_same_edge", 32'(sw_if.req_ack), 32'h0);
    check("race busy_cleared", 32'(sw_if.out_busy), 32'h0);
    wait_ack(4, 10, cyc);
    sw_if.req[LOCAL] = 1'b0;
    check("race retry_ack_cycle", 32'(cyc), 32'd5);
    check("race out_busy", 32'(sw_if.out_busy), 32'h01);

    // Reset asserted during S_ROUTE with two live allocations.
    do_reset();
    sw_if.header[WEST] = 32'h0201;
    sw_if.req[WEST]    = 1'b1;
    wait_ack(1, 10, cyc);
    sw_if.req[WEST]     = 1'b0;
    sw_if.sending[WEST] = 1'b1;
    sw_if.header[NORTH] = 32'h0100;
    sw_if.req[NORTH]    = 1'b1;
    wait_ack(2, 12, cyc);
    check("rst north_ack", 32'(cyc), 32'd5);
    sw_if.req[NORTH]     = 1'b0;
    sw_if.sending[NORTH] = 1'b1;
    sw_if.header[LOCAL]  = 32'h0001;
    sw_if.req[LOCAL]     = 1'b1;
    repeat (4) @(negedge clk_i);   // now mid S_ROUTE
    check("rst pre_busy", 32'(sw_if.out_busy), 32'h09);
    rst_ni = 1'b0;
    #1;
    check("rst req_ack",  32'(sw_if.req_ack),  32'h0);
    check("rst out_busy", 32'(sw_if.out_busy), 32'h0);
    check("rst in_valid", 32'(sw_if.in_valid), 32'h0);
    check("rst out_sel",  32'(sw_if.out_sel),  32'h0);
    check("rst in_sel",   32'(sw_if.in_sel),   32'h0);
    sw_if.req     = '0;
    sw_if.sending = '0;
    repeat (2) @(negedge clk_i);
    rst_ni  = 1'b1;
    ack_acc = '0;
    repeat (10) begin
      @(negedge clk_i);
      ack_acc = ack_acc | sw_if.req_ack;
    end
    check("rst no_ack_after", 32'(ack_acc), 32'h0);
    check("rst busy_after", 32'(sw_if.out_busy), 32'h0);
    sw_if.header[LOCAL] = 32'h0101;
    sw_if.req[LOCAL]    = 1'b1;
    wait_ack(4, 10, cyc);
    sw_if.req[LOCAL] = 1'b0;
    check("rst idle_latency", 32'(cyc), 32'd3);
    check("rst local_busy", 32'(sw_if.out_busy), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
